// File: rtl/frame_buffer.sv
// frame_buffer: ping-pong capture of multi-channel sample frames,
// streamed out channel-major over a registered valid/ready port.
module frame_buffer #(
   parameter int N          = 1024,
   parameter int DATA_WIDTH = 14,
   parameter int NUM_CHAN   = 2,
   parameter int TRIG_MODE  = 1,
   localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int IW = $clog2(N)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic [NUM_CHAN*DATA_WIDTH-1:0] din_i,
   input  logic                           trig_i,
   output logic [DATA_WIDTH-1:0]          dout_o,
   output logic [CW-1:0]                  dout_chan_o,
   output logic                           dout_valid_o,
   input  logic                           dout_ready_i,
   output logic                           dout_last_o,
   output logic [7:0]                     frame_id_o,
   output logic [15:0]                    drop_cnt_o,
   output logic                           busy_o
);

   typedef enum logic [1:0] {W_ARMED, W_FILL, W_DROP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_e;

   localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
   localparam logic [CW-1:0] CHAN_LAST = CW'(NUM_CHAN - 1);
   localparam wstate_e       W_START   = (TRIG_MODE != 0) ? W_ARMED : W_FILL;

   logic [DATA_WIDTH-1:0] mem_q [2][NUM_CHAN][N];

   wstate_e               w_state_q;
   logic [IW-1:0]         wr_idx_q;
   logic                  wr_bank_q;
   logic [15:0]           drop_q;
   logic [1:0]            full_q;
   logic [1:0]            full_d;

   rstate_e               r_state_q;
   logic                  rd_bank_q;
   logic [CW-1:0]         rd_chan_q;
   logic [IW-1:0]         rd_idx_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [CW-1:0]         chan_q;
   logic                  valid_q;
   logic                  last_q;
   logic                  final_q;
   logic [7:0]            fid_q;

   logic                  rd_done;
   logic                  rd_take;
   logic                  free_cur;
   logic                  free_nxt;
   logic                  wr_start;
   logic                  wr_we;
   logic                  wr_done;
   logic [DATA_WIDTH-1:0] rd_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A bank released by the reader this very cycle already counts as free.
   assign rd_done  = (r_state_q == R_STREAM) & valid_q & dout_ready_i & final_q;
   assign free_cur = ~full_q[wr_bank_q] | (rd_done & (rd_bank_q == wr_bank_q));
   assign free_nxt = ~full_q[~wr_bank_q] | (rd_done & (rd_bank_q != wr_bank_q));
   assign wr_start = (w_state_q == W_ARMED) & trig_i & free_cur;
   assign wr_we    = ~rst_i & en_i & ((w_state_q == W_FILL) | wr_start);
   assign wr_done  = en_i & (w_state_q == W_FILL) & (wr_idx_q == IDX_LAST);
   assign rd_word  = mem_q[rd_bank_q][rd_chan_q][rd_idx_q];
   assign rd_take  = (r_state_q == R_LOAD) |
                     ((r_state_q == R_STREAM) & dout_ready_i & ~final_q);

   // Writer: arm on trigger, fill one bank, or skip a frame on overrun.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_START;
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         drop_q    <= '0;
      end else begin
         unique case (w_state_q)
            W_ARMED: begin
               if (trig_i) begin
                  if (free_cur) begin
                     w_state_q <= W_FILL;
                     if (en_i) wr_idx_q <= wr_idx_q + 1'b1;
                  end else begin
                     w_state_q <= W_DROP;
                     drop_q    <= sat_inc(drop_q);
                  end
               end
            end
            W_FILL: begin
               if (en_i) begin
                  wr_idx_q <= wr_idx_q + 1'b1;
                  if (wr_idx_q == IDX_LAST) begin
                     wr_bank_q <= ~wr_bank_q;
                     if (TRIG_MODE != 0) begin
                        w_state_q <= W_ARMED;
                     end else if (!free_nxt) begin
                        w_state_q <= W_DROP;
                        drop_q    <= sat_inc(drop_q);
                     end
                  end
               end
            end
            W_DROP: begin
               if (TRIG_MODE != 0) begin
                  if (trig_i) w_state_q <= W_ARMED;
               end else if (en_i) begin
                  wr_idx_q <= wr_idx_q + 1'b1;
                  if (wr_idx_q == IDX_LAST) begin
                     if (free_cur) begin
                        w_state_q <= W_FILL;
                     end else begin
                        drop_q <= sat_inc(drop_q);
                     end
                  end
               end
            end
            default: w_state_q <= W_START;
         endcase
      end
   end

   // Sample storage; one row across all channels per strobe.
   always_ff @(posedge clk_i) begin
      if (wr_we) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            mem_q[wr_bank_q][c][wr_idx_q] <= din_i[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Full flags: set by a completed frame, cleared by its final beat.
   always_comb begin
      full_d = full_q;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
      if (wr_done) full_d[wr_bank_q] = 1'b1;
   end

   // Full flag register.
   always_ff @(posedge clk_i) begin
      if (rst_i) full_q <= '0;
      else       full_q <= full_d;
   end

   // Reader: banks drain in the same alternating order they were filled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         rd_bank_q <= 1'b0;
         rd_chan_q <= '0;
         rd_idx_q  <= '0;
         dout_q    <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         final_q   <= 1'b0;
         fid_q     <= '0;
      end else begin
         if (rd_take) begin
            dout_q   <= rd_word;
            chan_q   <= rd_chan_q;
            last_q   <= (rd_idx_q == IDX_LAST);
            final_q  <= (rd_idx_q == IDX_LAST) && (rd_chan_q == CHAN_LAST);
            valid_q  <= 1'b1;
            rd_idx_q <= rd_idx_q + 1'b1;
            if (rd_idx_q == IDX_LAST) begin
               rd_chan_q <= (rd_chan_q == CHAN_LAST) ? '0 : rd_chan_q + 1'b1;
            end
         end
         unique case (r_state_q)
            R_IDLE: begin
               if (full_q[rd_bank_q]) r_state_q <= R_LOAD;
            end
            R_LOAD: r_state_q <= R_STREAM;
            R_STREAM: begin
               if (rd_done) begin
                  valid_q   <= 1'b0;
                  last_q    <= 1'b0;
                  final_q   <= 1'b0;
                  fid_q     <= fid_q + 8'd1;
                  rd_bank_q <= ~rd_bank_q;
                  r_state_q <= full_q[~rd_bank_q] ? R_LOAD : R_IDLE;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign dout_o       = dout_q;
   assign dout_chan_o  = chan_q;
   assign dout_valid_o = valid_q;
   assign dout_last_o  = last_q;
   assign frame_id_o   = fid_q;
   assign drop_cnt_o   = drop_q;
   assign busy_o       = (w_state_q == W_FILL) & ~rst_i;

endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: triggered and free-run instances checked against
// a frame-level model of captured samples and expected beats.
module tb_frame_buffer;

   localparam int N  = 8;
   localparam int DW = 14;
   localparam int NC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          en1, trig1, rdy1;
   logic [NC*DW-1:0] din1;
   logic [DW-1:0] dout1;
   logic [0:0]    chan1;
   logic          valid1, last1, busy1;
   logic [7:0]    fid1;
   logic [15:0]   drop1;

   logic          en0, trig0, rdy0;
   logic [NC*DW-1:0] din0;
   logic [DW-1:0] dout0;
   logic [0:0]    chan0;
   logic          valid0, last0, busy0;
   logic [7:0]    fid0;
   logic [15:0]   drop0;

   frame_buffer #(.N(N), .DATA_WIDTH(DW), .NUM_CHAN(NC), .TRIG_MODE(1)) u1 (
      .clk_i(clk), .rst_i(rst), .en_i(en1), .din_i(din1), .trig_i(trig1),
      .dout_o(dout1), .dout_chan_o(chan1), .dout_valid_o(valid1),
      .dout_ready_i(rdy1), .dout_last_o(last1), .frame_id_o(fid1),
      .drop_cnt_o(drop1), .busy_o(busy1));

   frame_buffer #(.N(N), .DATA_WIDTH(DW), .NUM_CHAN(NC), .TRIG_MODE(0)) u0 (
      .clk_i(clk), .rst_i(rst), .en_i(en0), .din_i(din0), .trig_i(trig0),
      .dout_o(dout0), .dout_chan_o(chan0), .dout_valid_o(valid0),
      .dout_ready_i(rdy0), .dout_last_o(last0), .frame_id_o(fid0),
      .drop_cnt_o(drop0), .busy_o(busy0));

   typedef struct {
      logic [DW-1:0] d;
      logic          ch;
      logic          last;
      logic [7:0]    fid;
      int            cyc;
   } beat_t;

   beat_t         rx[$];
   beat_t         exq[$];
   beat_t         exq0[$];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            stall_err = 0;
   int            stall_cyc = 0;
   logic [DW-1:0] smp [NC][N];
   logic [7:0]    exp_fid = 8'd0;
   bit            bp_on = 1'b0;

   logic          pv = 1'b0, pr = 1'b0, pc = 1'b0, pl = 1'b0;
   logic [DW-1:0] pd = '0;
   logic [7:0]    pf = '0;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (bp_on) begin
         #1;
         rdy1 = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            stall_cyc++;
            if (!valid1 || dout1 !== pd || chan1 !== pc ||
                last1 !== pl || fid1 !== pf) stall_err++;
         end
         if (valid1 && rdy1) begin
            b.d = dout1; b.ch = chan1; b.last = last1;
            b.fid = fid1; b.cyc = cyc;
            rx.push_back(b);
         end
         pv = valid1; pr = rdy1; pd = dout1;
         pc = chan1;  pl = last1; pf = fid1;
      end
   end

   task automatic gen_frame(input bit ramp);
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < N; k++)
            smp[c][k] = ramp ? DW'(c * 100 + k) : DW'($urandom);
   endtask

   task automatic push_exp();
      beat_t b;
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < N; k++) begin
            b.d = smp[c][k]; b.ch = c[0]; b.last = (k == N - 1);
            b.fid = exp_fid; b.cyc = 0;
            exq.push_back(b);
         end
      exp_fid++;
   endtask

   task automatic send_frame(input bit mid_trig);
      for (int k = 0; k < N; k++) begin
         trig1 = (k == 0) || (mid_trig && k == 3);
         en1 = 1'b1;
         for (int c = 0; c < NC; c++) din1[c*DW +: DW] = smp[c][k];
         @(posedge clk); #1;
      end
      en1 = 1'b0;
      trig1 = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 2000; i++) begin
         if (rx.size() >= n) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_fid = 8'd0;
      rx.delete();
      exq.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({valid1, last1, dout1, chan1, fid1, drop1, busy1} !== '0) begin
         fails++;
         $display("FAIL reset_outs_u1: got v=%0d l=%0d d=%0d c=%0d f=%0d dr=%0d b=%0d want all 0",
                  valid1, last1, dout1, chan1, fid1, drop1, busy1);
      end
      tests++;
      if ({valid0, last0, dout0, chan0, fid0, drop0, busy0} !== '0) begin
         fails++;
         $display("FAIL reset_outs_u0: got v=%0d f=%0d dr=%0d b=%0d want all 0",
                  valid0, fid0, drop0, busy0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (busy1 !== 1'b0) begin
         fails++;
         $display("FAIL armed_after_reset: got busy=%0d want 0", busy1);
      end
      tests++;
      if (busy0 !== 1'b1) begin
         fails++;
         $display("FAIL fill_after_reset: got busy=%0d want 1", busy0);
      end
   endtask

   task automatic test_ramp();
      int lat;
      rx.delete(); exq.delete();
      rdy1 = 1'b1;
      gen_frame(1'b1);
      push_exp();
      send_frame(1'b1);
      lat = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid1) break;
         lat++;
      end
      tests++;
      if (lat !== 2) begin
         fails++;
         $display("FAIL ramp_latency: got %0d want 2", lat);
      end
      wait_rx(16);
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < exq.size(); i++) begin
         tests++;
         if (i >= rx.size()) begin
            fails++;
            $display("FAIL ramp_beat %0d: missing, want d=%0d", i, exq[i].d);
         end else if (rx[i].d !== exq[i].d || rx[i].ch !== exq[i].ch ||
                      rx[i].last !== exq[i].last || rx[i].fid !== exq[i].fid) begin
            fails++;
            $display("FAIL ramp_beat %0d: got d=%0d ch=%0d l=%0d f=%0d want d=%0d ch=%0d l=%0d f=%0d",
                     i, rx[i].d, rx[i].ch, rx[i].last, rx[i].fid,
                     exq[i].d, exq[i].ch, exq[i].last, exq[i].fid);
         end
      end
      tests++;
      if (rx.size() != exq.size()) begin
         fails++;
         $display("FAIL ramp_count: got %0d want %0d", rx.size(), exq.size());
      end else begin
         tests++;
         if (rx[15].cyc - rx[0].cyc !== 15) begin
            fails++;
            $display("FAIL ramp_no_bubble: got span %0d want 15", rx[15].cyc - rx[0].cyc);
         end
      end
      tests++;
      if (fid1 !== 8'd1) begin
         fails++;
         $display("FAIL ramp_fid_after: got %0d want 1", fid1);
      end
   endtask

   task automatic test_backpressure();
      rx.delete(); exq.delete();
      stall_err = 0;
      stall_cyc = 0;
      bp_on = 1'b1;
      for (int f = 0; f < 3; f++) begin
         gen_frame(1'b0);
         push_exp();
         send_frame(1'($urandom_range(0, 1)));
         wait_rx(16 * (f + 1));
      end
      bp_on = 1'b0;
      @(posedge clk); #1;
      rdy1 = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < exq.size(); i++) begin
         tests++;
         if (i >= rx.size()) begin
            fails++;
            $display("FAIL bp_beat %0d: missing, want d=%0d", i, exq[i].d);
         end else if (rx[i].d !== exq[i].d || rx[i].ch !== exq[i].ch ||
                      rx[i].last !== exq[i].last || rx[i].fid !== exq[i].fid) begin
            fails++;
            $display("FAIL bp_beat %0d: got d=%0d ch=%0d l=%0d f=%0d want d=%0d ch=%0d l=%0d f=%0d",
                     i, rx[i].d, rx[i].ch, rx[i].last, rx[i].fid,
                     exq[i].d, exq[i].ch, exq[i].last, exq[i].fid);
         end
      end
      tests++;
      if (rx.size() != exq.size()) begin
         fails++;
         $display("FAIL bp_count: got %0d want %0d", rx.size(), exq.size());
      end
      tests++;
      if (stall_err !== 0) begin
         fails++;
         $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err);
      end
      tests++;
      if (stall_cyc == 0) begin
         fails++;
         $display("FAIL bp_stalls_seen: got %0d want >0", stall_cyc);
      end
      tests++;
      if (drop1 !== 16'd0) begin
         fails++;
         $display("FAIL bp_drop: got %0d want 0", drop1);
      end
   endtask

   task automatic test_overrun();
      pulse_reset();
      rdy1 = 1'b0;
      gen_frame(1'b0); push_exp(); send_frame(1'b0);
      repeat (3) @(posedge clk);
      #1;
      gen_frame(1'b0); push_exp(); send_frame(1'b0);
      repeat (3) @(posedge clk);
      #1;
      gen_frame(1'b0); send_frame(1'b0);
      tests++;
      if (drop1 !== 16'd1) begin
         fails++;
         $display("FAIL ovr_drop: got %0d want 1", drop1);
      end
      tests++;
      if (busy1 !== 1'b0 || valid1 !== 1'b1 || fid1 !== 8'd0) begin
         fails++;
         $display("FAIL ovr_hold: got busy=%0d valid=%0d fid=%0d want 0 1 0",
                  busy1, valid1, fid1);
      end
      trig1 = 1'b1;
      @(posedge clk); #1;
      trig1 = 1'b0;
      rdy1 = 1'b1;
      wait_rx(32);
      gen_frame(1'b0); push_exp(); send_frame(1'b0);
      wait_rx(48);
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < exq.size(); i++) begin
         tests++;
         if (i >= rx.size()) begin
            fails++;
            $display("FAIL ovr_beat %0d: missing, want d=%0d", i, exq[i].d);
         end else if (rx[i].d !== exq[i].d || rx[i].ch !== exq[i].ch ||
                      rx[i].last !== exq[i].last || rx[i].fid !== exq[i].fid) begin
            fails++;
            $display("FAIL ovr_beat %0d: got d=%0d ch=%0d l=%0d f=%0d want d=%0d ch=%0d l=%0d f=%0d",
                     i, rx[i].d, rx[i].ch, rx[i].last, rx[i].fid,
                     exq[i].d, exq[i].ch, exq[i].last, exq[i].fid);
         end
      end
      tests++;
      if (rx.size() != exq.size()) begin
         fails++;
         $display("FAIL ovr_count: got %0d want %0d", rx.size(), exq.size());
      end
      tests++;
      if (drop1 !== 16'd1) begin
         fails++;
         $display("FAIL ovr_drop_final: got %0d want 1", drop1);
      end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      rdy1 = 1'b1;
      gen_frame(1'b0);
      for (int k = 0; k < 5; k++) begin
         trig1 = (k == 0);
         en1 = 1'b1;
         for (int c = 0; c < NC; c++) din1[c*DW +: DW] = smp[c][k];
         @(posedge clk); #1;
      end
      en1 = 1'b0;
      trig1 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      tests++;
      if (rx.size() !== 0 || valid1 !== 1'b0 || fid1 !== 8'd0) begin
         fails++;
         $display("FAIL rst_midframe: got beats=%0d valid=%0d fid=%0d want 0 0 0",
                  rx.size(), valid1, fid1);
      end
      rdy1 = 1'b0;
      gen_frame(1'b0);
      send_frame(1'b0);
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (valid1 !== 1'b1) begin
         fails++;
         $display("FAIL rst_prestream: got valid=%0d want 1", valid1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (valid1 !== 1'b0 || fid1 !== 8'd0) begin
         fails++;
         $display("FAIL rst_midstream: got valid=%0d fid=%0d want 0 0", valid1, fid1);
      end
      rst = 1'b0;
      rdy1 = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      tests++;
      if (rx.size() !== 0) begin
         fails++;
         $display("FAIL rst_no_output: got %0d beats want 0", rx.size());
      end
      gen_frame(1'b0); push_exp(); send_frame(1'b0);
      wait_rx(16);
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < exq.size(); i++) begin
         tests++;
         if (i >= rx.size()) begin
            fails++;
            $display("FAIL rst_beat %0d: missing, want d=%0d", i, exq[i].d);
         end else if (rx[i].d !== exq[i].d || rx[i].ch !== exq[i].ch ||
                      rx[i].last !== exq[i].last || rx[i].fid !== exq[i].fid) begin
            fails++;
            $display("FAIL rst_beat %0d: got d=%0d ch=%0d l=%0d f=%0d want d=%0d ch=%0d l=%0d f=%0d",
                     i, rx[i].d, rx[i].ch, rx[i].last, rx[i].fid,
                     exq[i].d, exq[i].ch, exq[i].last, exq[i].fid);
         end
      end
      tests++;
      if (rx.size() != exq.size()) begin
         fails++;
         $display("FAIL rst_count: got %0d want %0d", rx.size(), exq.size());
      end
   endtask

   task automatic test_freerun();
      localparam int FRAMES = 257;
      int got;
      tests++;
      if (fid0 !== 8'd0 || drop0 !== 16'd0) begin
         fails++;
         $display("FAIL free_start: got fid=%0d drop=%0d want 0 0", fid0, drop0);
      end
      exq0.delete();
      rdy0 = 1'b1;
      got = 0;
      fork
         begin
            logic [DW-1:0] fr [NC][N];
            beat_t b;
            for (int f = 0; f < FRAMES; f++) begin
               for (int k = 0; k < N; k++) begin
                  en0 = 1'b0;
                  repeat (2) @(posedge clk);
                  #1;
                  en0 = 1'b1;
                  for (int c = 0; c < NC; c++) begin
                     fr[c][k] = DW'($urandom);
                     din0[c*DW +: DW] = fr[c][k];
                  end
                  @(posedge clk); #1;
               end
               en0 = 1'b0;
               for (int c = 0; c < NC; c++)
                  for (int k = 0; k < N; k++) begin
                     b.d = fr[c][k]; b.ch = c[0]; b.last = (k == N - 1);
                     b.fid = 8'(f); b.cyc = 0;
                     exq0.push_back(b);
                  end
            end
         end
         begin
            beat_t e;
            for (int t = 0; t < FRAMES * N * 3 + 500; t++) begin
               if (got >= FRAMES * NC * N) break;
               @(negedge clk);
               if (valid0 && rdy0) begin
                  tests++;
                  got++;
                  if (exq0.size() == 0) begin
                     fails++;
                     $display("FAIL free_beat %0d: unexpected d=%0d", got, dout0);
                  end else begin
                     e = exq0.pop_front();
                     if (dout0 !== e.d || chan0 !== e.ch ||
                         last0 !== e.last || fid0 !== e.fid) begin
                        fails++;
                        $display("FAIL free_beat %0d: got d=%0d ch=%0d l=%0d f=%0d want d=%0d ch=%0d l=%0d f=%0d",
                                 got, dout0, chan0, last0, fid0, e.d, e.ch, e.last, e.fid);
                     end
                  end
               end
            end
         end
      join
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (got !== FRAMES * NC * N) begin
         fails++;
         $display("FAIL free_count: got %0d beats want %0d", got, FRAMES * NC * N);
      end
      tests++;
      if (fid0 !== 8'd1) begin
         fails++;
         $display("FAIL free_fid_wrap: got %0d want 1", fid0);
      end
      tests++;
      if (drop0 !== 16'd0) begin
         fails++;
         $display("FAIL free_drop: got %0d want 0", drop0);
      end
   endtask

   initial begin
      rst = 1'b1;
      en1 = 1'b0; trig1 = 1'b0; rdy1 = 1'b1; din1 = '0;
      en0 = 1'b0; trig0 = 1'b0; rdy0 = 1'b1; din0 = '0;
      test_reset();
      test_ramp();
      test_backpressure();
      test_overrun();
      test_reset_mid();
      test_freerun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
